// File: rtl/lag_pl_credit_tx_pkg.sv
// Shared types and helpers for the physical-lane credit transmitter.
// Flit type, credit-width helper and default geometry.
package lag_pl_credit_tx_pkg;

    localparam int unsigned FlitW = 8;

    typedef logic [FlitW-1:0] fifo_elements_t;

    // Ceiling log2, used to size credit counters as clog2(size+1).
    function automatic int unsigned lag_clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    localparam int unsigned DefSize = 3;
    localparam int unsigned DefN    = 4;
    localparam int unsigned DefCw   = lag_clog2(DefSize + 1);

endpackage

// File: rtl/lag_credit_counter.sv
// Per-lane credit counter: decrements on a sent flit, increments on a returned credit,
// saturates at Size. Optional sticky overflow flag when LAG_PL_CREDIT_CHECK_EN is defined.
module lag_credit_counter #(
    parameter int unsigned Size = 3,
    parameter int unsigned CW   = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dec,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          nonzero,
    output logic          full,
    output logic          err
);

    localparam logic [CW-1:0] SizeC = CW'(Size);

    logic [CW-1:0] count_q, count_d;

    assign count   = count_q;
    assign nonzero = (count_q != '0);
    assign full    = (count_q == SizeC);

    // Next credit count; simultaneous inc/dec cancel, overflow saturates at Size.
    always_comb begin
        count_d = count_q;
        if (dec && !inc && nonzero) begin
            count_d = count_q - CW'(1);
        end else if (inc && !dec && !full) begin
            count_d = count_q + CW'(1);
        end
    end

    // Credit register, restored to a full FIFO's worth on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= SizeC;
        end else begin
            count_q <= count_d;
        end
    end

`ifdef LAG_PL_CREDIT_CHECK_EN
    logic err_q, err_d;

    assign err = err_q;

    // A credit returned while already full means the downstream popped a flit it never got.
    always_comb begin
        err_d = err_q | (inc & ~dec & full);
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    // Flag the overflow in simulation as it happens.
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_no_credit_overflow: assert (!(inc && !dec && full));
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: rtl/lag_pl_credit_tx.sv
// Credit-based transmitter for n downstream PL FIFOs of depth size.
// Flits are forwarded through one register stage as push + data_out per lane.
// Optional feature macro: LAG_PL_CREDIT_CHECK_EN (sticky per-lane credit overflow flag).
module lag_pl_credit_tx
    import lag_pl_credit_tx_pkg::*;
#(
    parameter int unsigned size = 3,
    parameter int unsigned n    = 4,
    parameter int unsigned CW   = lag_clog2(size + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [n-1:0]          in_valid,
    output logic [n-1:0]          in_ready,
    input  fifo_elements_t [n-1:0] in_data,
    output logic [n-1:0]          push,
    output fifo_elements_t [n-1:0] data_out,
    input  logic [n-1:0]          credit_in,
    output logic [n-1:0][CW-1:0]  credits,
    output logic [n-1:0]          lane_idle,
    output logic [n-1:0]          cred_err
);

    logic [n-1:0]           acc;
    logic [n-1:0]           full;
    logic [n-1:0]           push_q, push_d;
    fifo_elements_t [n-1:0] data_q, data_d;

    for (genvar i = 0; i < n; i++) begin : g_lane
        lag_credit_counter #(
            .Size (size),
            .CW   (CW)
        ) u_credit_counter (
            .clk     (clk),
            .rst     (rst),
            .dec     (acc[i]),
            .inc     (credit_in[i]),
            .count   (credits[i]),
            .nonzero (in_ready[i]),
            .full    (full[i]),
            .err     (cred_err[i])
        );
    end

    // Accept only into lanes with a free downstream slot; data holds between flits.
    always_comb begin
        acc    = in_valid & in_ready;
        push_d = acc;
        data_d = data_q;
        for (int i = 0; i < n; i++) begin
            if (acc[i]) begin
                data_d[i] = in_data[i];
            end
        end
    end

    // Output stage; reset drops any in-flight push.
    always_ff @(posedge clk) begin
        if (rst) begin
            push_q <= '0;
            data_q <= '0;
        end else begin
            push_q <= push_d;
            data_q <= data_d;
        end
    end

    assign push      = push_q;
    assign data_out  = data_q;
    assign lane_idle = full & ~push_q;

endmodule

// File: tb/tb_lag_pl_credit_tx.sv
// Self-checking bench for lag_pl_credit_tx (n=4, size=3): directed table, then random
// stimulus against a credit-count reference model.
module tb_lag_pl_credit_tx;
    import lag_pl_credit_tx_pkg::*;

    localparam int N    = 4;
    localparam int SIZE = 3;
`ifdef LAG_PL_CREDIT_CHECK_EN
    localparam bit ChkEn = 1'b1;
`else
    localparam bit ChkEn = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [N-1:0]           in_valid = '0;
    logic [N-1:0]           in_ready;
    fifo_elements_t [N-1:0] in_data = '0;
    logic [N-1:0]           push;
    fifo_elements_t [N-1:0] data_out;
    logic [N-1:0]           credit_in = '0;
    logic [N-1:0][1:0]      credits;
    logic [N-1:0]           lane_idle;
    logic [N-1:0]           cred_err;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lag_pl_credit_tx #(
        .size (SIZE),
        .n    (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .push      (push),
        .data_out  (data_out),
        .credit_in (credit_in),
        .credits   (credits),
        .lane_idle (lane_idle),
        .cred_err  (cred_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] v;
        logic [3:0] c;
        logic [3:0] exp_push;
        logic [7:0] exp_cr;   // {lane3, lane2, lane1, lane0}, 2 bits each
    } vec_t;

    function automatic logic [7:0] cr(input int l3, input int l2, input int l1, input int l0);
        return {2'(l3), 2'(l2), 2'(l1), 2'(l0)};
    endfunction

    function automatic logic [3:0] ready_of(input logic [7:0] c);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (c[2*i+:2] != 2'd0);
        return r;
    endfunction

    function automatic logic [3:0] idle_of(input logic [7:0] c, input logic [3:0] p);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (c[2*i+:2] == 2'(SIZE)) && !p[i];
        return r;
    endfunction

    vec_t tbl[18];

    // Reference model state for the random phase (and data/err tracking in the table).
    int             m_cred[N];
    logic [N-1:0]   m_push;
    fifo_elements_t m_data[N];
    logic [N-1:0]   m_err;

    initial begin
        logic [7:0] prev_cr;
        logic [3:0] acc;
        logic [3:0] mready;

        tbl[0]  = '{1'b1, 4'h0, 4'h0, 4'h0, cr(3, 3, 3, 3)};
        // Lane 0 drains: three pulses, fourth flit refused.
        tbl[1]  = '{1'b0, 4'h1, 4'h0, 4'h1, cr(3, 3, 3, 2)};
        tbl[2]  = '{1'b0, 4'h1, 4'h0, 4'h1, cr(3, 3, 3, 1)};
        tbl[3]  = '{1'b0, 4'h1, 4'h0, 4'h1, cr(3, 3, 3, 0)};
        tbl[4]  = '{1'b0, 4'h1, 4'h0, 4'h0, cr(3, 3, 3, 0)};
        // Lane 1 down to 1, then accept + credit in the same cycle.
        tbl[5]  = '{1'b0, 4'h2, 4'h0, 4'h2, cr(3, 3, 2, 0)};
        tbl[6]  = '{1'b0, 4'h2, 4'h0, 4'h2, cr(3, 3, 1, 0)};
        tbl[7]  = '{1'b0, 4'h2, 4'h2, 4'h2, cr(3, 3, 1, 0)};
        tbl[8]  = '{1'b0, 4'h0, 4'h0, 4'h0, cr(3, 3, 1, 0)};
        // Lane 2 down to 0, then credit while valid: not accepted this cycle.
        tbl[9]  = '{1'b0, 4'h4, 4'h0, 4'h4, cr(3, 2, 1, 0)};
        tbl[10] = '{1'b0, 4'h4, 4'h0, 4'h4, cr(3, 1, 1, 0)};
        tbl[11] = '{1'b0, 4'h4, 4'h0, 4'h4, cr(3, 0, 1, 0)};
        tbl[12] = '{1'b0, 4'h4, 4'h4, 4'h0, cr(3, 1, 1, 0)};
        // Lane 3 overflow: saturates.
        tbl[13] = '{1'b0, 4'h0, 4'h8, 4'h0, cr(3, 1, 1, 0)};
        tbl[14] = '{1'b0, 4'h0, 4'h7, 4'h0, cr(3, 2, 2, 1)};
        // All lanes streaming, then reset mid-operation.
        tbl[15] = '{1'b0, 4'hf, 4'h0, 4'hf, cr(2, 1, 1, 0)};
        tbl[16] = '{1'b1, 4'hf, 4'h0, 4'h0, cr(3, 3, 3, 3)};
        tbl[17] = '{1'b0, 4'h0, 4'h0, 4'h0, cr(3, 3, 3, 3)};

        prev_cr = cr(3, 3, 3, 3);
        m_err   = '0;
        for (int i = 0; i < N; i++) m_data[i] = '0;
        #2;
        for (int r = 0; r < 18; r++) begin
            rst       = tbl[r].rst;
            in_valid  = tbl[r].v;
            credit_in = tbl[r].c;
            for (int i = 0; i < N; i++) in_data[i] = fifo_elements_t'(r * 16 + i * 4 + 1);
            #1;
            if (r > 0) chk("tbl_in_ready_pre", 32'(in_ready), 32'(ready_of(prev_cr)));
            acc = tbl[r].v & ready_of(prev_cr);
            for (int i = 0; i < N; i++) begin
                if (tbl[r].rst) begin
                    m_data[i] = '0;
                    m_err[i]  = 1'b0;
                end else begin
                    if (acc[i]) m_data[i] = in_data[i];
                    if (ChkEn && tbl[r].c[i] && !acc[i] && prev_cr[2*i+:2] == 2'(SIZE))
                        m_err[i] = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            chk("tbl_push", 32'(push), 32'(tbl[r].exp_push));
            for (int i = 0; i < N; i++) begin
                chk("tbl_credits", 32'(credits[i]), 32'(tbl[r].exp_cr[2*i+:2]));
                chk("tbl_data_out", 32'(data_out[i]), 32'(m_data[i]));
            end
            chk("tbl_in_ready", 32'(in_ready), 32'(ready_of(tbl[r].exp_cr)));
            chk("tbl_lane_idle", 32'(lane_idle), 32'(idle_of(tbl[r].exp_cr, tbl[r].exp_push)));
            chk("tbl_cred_err", 32'(cred_err), 32'(m_err));
            prev_cr = tbl[r].exp_cr;
        end

        // Random phase: model starts from the post-table state (just out of reset, idle).
        for (int i = 0; i < N; i++) begin
            m_cred[i] = SIZE;
            m_data[i] = '0;
        end
        m_push = '0;
        m_err  = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            rst = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < N; i++) begin
                in_valid[i]  = ($urandom_range(0, 9) < 6);
                credit_in[i] = ($urandom_range(0, 9) < 4);
                in_data[i]   = fifo_elements_t'($urandom);
            end
            #1;
            for (int i = 0; i < N; i++) mready[i] = (m_cred[i] > 0);
            chk("rnd_in_ready_pre", 32'(in_ready), 32'(mready));
            for (int i = 0; i < N; i++) begin
                if (rst) begin
                    m_cred[i] = SIZE;
                    m_push[i] = 1'b0;
                    m_data[i] = '0;
                    m_err[i]  = 1'b0;
                end else begin
                    acc[i]    = in_valid[i] && mready[i];
                    m_push[i] = acc[i];
                    if (acc[i]) m_data[i] = in_data[i];
                    if (acc[i] && !credit_in[i]) begin
                        m_cred[i] = m_cred[i] - 1;
                    end else if (!acc[i] && credit_in[i]) begin
                        if (m_cred[i] == SIZE) begin
                            if (ChkEn) m_err[i] = 1'b1;
                        end else begin
                            m_cred[i] = m_cred[i] + 1;
                        end
                    end
                end
            end
            @(posedge clk);
            #1;
            chk("rnd_push", 32'(push), 32'(m_push));
            for (int i = 0; i < N; i++) begin
                chk("rnd_credits", 32'(credits[i]), 32'(m_cred[i]));
                chk("rnd_data_out", 32'(data_out[i]), 32'(m_data[i]));
                chk("rnd_lane_idle", 32'(lane_idle[i]),
                    32'((m_cred[i] == SIZE) && !m_push[i]));
            end
            chk("rnd_cred_err", 32'(cred_err), 32'(m_err));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
